delay_addr_ctrl: RTL

- Address/strobe controller placed directly upstream of the team's dual-port sample RAM in the audio-delay path.
- Accepts one input sample per strobe and writes it into the RAM at a circular write pointer.
- Reads back the sample written `delay` strobes earlier, and presents it as a delayed output with a valid pulse.
- Mutes the output (drives zero) until enough samples exist in the buffer to satisfy the requested delay.

---
 rtl/delay_addr_ctrl_pkg.sv | 21 ++
 rtl/delay_addr_ctrl_if.sv | 34 +++
 rtl/delay_addr_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/delay_addr_ctrl_pkg.sv
// rtl/delay_addr_ctrl_pkg.sv - shared types and constants for the delay-line address controller
package delay_addr_ctrl_pkg;

    localparam int ADDR_W   = 9;
    localparam int SAMPLE_W = 8;
    localparam int DEPTH    = 2 ** ADDR_W;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // One sample travelling between request and output registers
    typedef struct packed {
        logic                valid;
        logic                mute;
        logic                bypass;
        logic [SAMPLE_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/delay_addr_ctrl_if.sv
// rtl/delay_addr_ctrl_if.sv - sample stream and sample-RAM port bundle for the delay controller
interface delay_addr_ctrl_if #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
);

    logic                     en;
    logic [DATA_WIDTH-1:0]    din;
    logic [ADDRESS_WIDTH-1:0] delay;

    logic                     ram_wr_en;
    logic                     ram_rd_en;
    logic [ADDRESS_WIDTH-1:0] ram_wr_addr;
    logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0]    ram_din;
    logic [DATA_WIDTH-1:0]    ram_dout;

    logic [DATA_WIDTH-1:0]    dout;
    logic                     dout_valid;
    logic                     filled;

    modport master (
        input  en, din, delay, ram_dout,
        output ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_din,
        output dout, dout_valid, filled
    );

    modport slave (
        output en, din, delay, ram_dout,
        input  ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_din,
        input  dout, dout_valid, filled
    );

endinterface

// File: rtl/delay_addr_ctrl.sv
// rtl/delay_addr_ctrl.sv - circular-buffer address/strobe controller for the audio delay RAM
// Writes one sample per strobe, reads the one written `delay` strobes back, outputs it 2 cycles later.
module delay_addr_ctrl
    import delay_addr_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int DATA_WIDTH    = SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst,
    delay_addr_ctrl_if.master bus
);

    localparam logic [ADDRESS_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    stage_t                   s1_q, s1_d;
    logic [DATA_WIDTH-1:0]    dout_q, dout_d;
    logic                     dout_valid_q, dout_valid_d;
    state_e                   state_q;

    // Strobes are gated by reset so the RAM never sees a write while the pointer is being cleared
    assign bus.ram_wr_en   = bus.en & ~rst;
    assign bus.ram_rd_en   = bus.en & (bus.delay != '0) & ~rst;
    assign bus.ram_wr_addr = wr_ptr_q;
    assign bus.ram_rd_addr = wr_ptr_q - bus.delay;
    assign bus.ram_din     = bus.din;

    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.filled      = (state_q == FULL);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        s1_d         = '0;
        dout_d       = dout_q;
        dout_valid_d = s1_q.valid;

        if (bus.en) begin
            wr_ptr_d = wr_ptr_q + ADDR_ONE;
            if (fill_cnt_q != CNT_MAX) begin
                fill_cnt_d = fill_cnt_q + ADDR_ONE;
            end
            s1_d.valid  = 1'b1;
            s1_d.mute   = (fill_cnt_q < bus.delay);
            s1_d.bypass = (bus.delay == '0);
            s1_d.data   = bus.din;
        end

        // Zero delay never reads the RAM, so the captured input is the output
        if (s1_q.valid) begin
            if (s1_q.mute) begin
                dout_d = '0;
            end else if (s1_q.bypass) begin
                dout_d = s1_q.data;
            end else begin
                dout_d = bus.ram_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            s1_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            state_q      <= FILL;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            s1_q         <= s1_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            case (state_q)
                FILL: if (bus.en && fill_cnt_d == CNT_MAX) state_q <= FULL;
                FULL: state_q <= FULL;
                default: state_q <= FILL;
            endcase
        end
    end

endmodule
